// File: rtl/jtag_pkg.sv
// Shared types and TMS sequencing constants for the JTAG IDCODE reader.
package jtag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TLR,
    ST_NAV,
    ST_SHIFT,
    ST_EXIT
  } state_e;

  localparam int         TLR_CYCLES = 5;
  // TMS patterns are consumed LSB first, one bit per TCK period.
  localparam logic [3:0] NAV_TMS    = 4'b0010;
  localparam logic [1:0] EXIT_TMS   = 2'b01;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: CLK_DIV system cycles low, CLK_DIV high, with strobes that
// flag the system-clock edge on which TCK is about to rise or fall.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tck_q, tck_d;
  logic          wrap;

  assign wrap = en_i && (div_q == DIV_MAX);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    div_d = '0;
    tck_d = 1'b0;
    if (en_i) begin
      div_d = wrap ? '0 : div_q + DW'(1);
      tck_d = wrap ? ~tck_q : tck_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      tck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tck_q <= tck_d;
    end
  end

  assign tck_o  = tck_q;
  assign rise_o = wrap & ~tck_q;
  assign fall_o = wrap &  tck_q;

endmodule

// File: rtl/jtag_idcode_reader.sv
// Walks the TAP from reset into Shift-DR and captures the IDCODE, LSB first.
// Define IDCODE_CHECK_EN to build the registered EXPECTED comparator on MATCH.
module jtag_idcode_reader
  import jtag_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               CLK_DIV  = 4,
  parameter logic [WIDTH-1:0] EXPECTED = WIDTH'(32'h0000_0001)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             TDO,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ID,
  output logic             MATCH
);

  // Wide enough for both the TLR period count and the shift bit index.
  localparam int CW = $clog2(WIDTH + TLR_CYCLES);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             tms_q, tms_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] id_q, id_d;
  logic             tck_rise, tck_fall;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk    (CLK),
    .rst_n  (RST_N),
    .en_i   (busy_q),
    .tck_o  (TCK),
    .rise_o (tck_rise),
    .fall_o (tck_fall)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // The FSM steps only on TCK-fall strobes, which end one period and begin the next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tms_d   = tms_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shift_d = shift_q;
    id_d    = id_q;

    if (tck_rise && state_q == ST_SHIFT) shift_d = {TDO, shift_q[WIDTH-1:1]};

    unique case (state_q)
      ST_IDLE: if (START) begin
        state_d = ST_TLR;
        busy_d  = 1'b1;
        cnt_d   = '0;
        tms_d   = 1'b1;
      end
      ST_TLR: if (tck_fall) begin
        if (cnt_q == CW'(TLR_CYCLES - 1)) begin
          state_d = ST_NAV;
          cnt_d   = '0;
          tms_d   = NAV_TMS[0];
        end else begin
          cnt_d = cnt_inc;
          tms_d = 1'b1;
        end
      end
      ST_NAV: if (tck_fall) begin
        if (cnt_q == CW'(3)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          tms_d = NAV_TMS[cnt_inc[1:0]];
        end
      end
      ST_SHIFT: if (tck_fall) begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_EXIT;
          cnt_d   = '0;
          tms_d   = EXIT_TMS[0];
        end else begin
          cnt_d = cnt_inc;
          tms_d = (cnt_inc == CW'(WIDTH - 1));
        end
      end
      ST_EXIT: if (tck_fall) begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          tms_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          id_d    = shift_q;
        end else begin
          cnt_d = cnt_inc;
          tms_d = EXIT_TMS[1];
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        tms_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // The shift register is reset too, so an aborted read leaves no stale bits behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tms_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      shift_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tms_q   <= tms_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      shift_q <= shift_d;
      id_q    <= id_d;
    end
  end

`ifdef IDCODE_CHECK_EN
  logic match_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      match_q <= 1'b0;
    else if (done_d) match_q <= (shift_q == EXPECTED);
  end

  assign MATCH = match_q;
`else
  assign MATCH = 1'b0;
`endif

  assign TMS  = tms_q;
  assign TDI  = 1'b1;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ID   = id_q;

endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Directed bench: two reader instances (8-bit/div 1, 32-bit/div 4), each wired
// to a behavioural TAP model whose IDCODE DR returns a preloaded value.
module tb_jtag_idcode_reader;

`ifdef IDCODE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef enum logic [3:0] {
    TLR_S, RTI_S, SELDR, CAPDR, SHDR, EX1DR, PSDR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR
  } tap_e;

  function automatic tap_e tap_next(input tap_e s, input logic tms);
    case (s)
      TLR_S:   return tms ? TLR_S : RTI_S;
      RTI_S:   return tms ? SELDR : RTI_S;
      SELDR:   return tms ? SELIR : CAPDR;
      CAPDR:   return tms ? EX1DR : SHDR;
      SHDR:    return tms ? EX1DR : SHDR;
      EX1DR:   return tms ? UPDR  : PSDR;
      PSDR:    return tms ? EX2DR : PSDR;
      EX2DR:   return tms ? UPDR  : SHDR;
      UPDR:    return tms ? SELDR : RTI_S;
      SELIR:   return tms ? TLR_S : CAPIR;
      CAPIR:   return tms ? EX1IR : SHIR;
      SHIR:    return tms ? EX1IR : SHIR;
      EX1IR:   return tms ? UPIR  : PSIR;
      PSIR:    return tms ? EX2IR : PSIR;
      EX2IR:   return tms ? UPIR  : SHIR;
      default: return tms ? SELDR : RTI_S;
    endcase
  endfunction

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start8  = 1'b0;
  logic start32 = 1'b0;
  logic tdo8    = 1'b1;
  logic tdo32   = 1'b1;

  logic        tck8, tms8, tdi8, busy8, done8, match8;
  logic [7:0]  id8;
  logic        tck32, tms32, tdi32, busy32, done32, match32;
  logic [31:0] id32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_idcode_reader #(.WIDTH(8), .CLK_DIV(1), .EXPECTED(8'hA5)) u_dut8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .TDO(tdo8),
    .TCK(tck8), .TMS(tms8), .TDI(tdi8), .BUSY(busy8), .DONE(done8),
    .ID(id8), .MATCH(match8)
  );

  jtag_idcode_reader #(.WIDTH(32), .CLK_DIV(4), .EXPECTED(32'h1234_5679)) u_dut32 (
    .CLK(clk), .RST_N(rst_n), .START(start32), .TDO(tdo32),
    .TCK(tck32), .TMS(tms32), .TDI(tdi32), .BUSY(busy32), .DONE(done32),
    .ID(id32), .MATCH(match32)
  );

  // TAP models: TMS/TDO sampled on rising TCK, TDO driven on falling TCK.
  tap_e        tap8      = TLR_S;
  tap_e        tap32     = TLR_S;
  logic [7:0]  idcode8   = 8'hA5;
  logic [7:0]  dr8       = '0;
  logic [31:0] idcode32  = 32'h1234_5679;
  logic [31:0] dr32      = '0;
  logic [63:0] trace8    = '0;
  logic [63:0] trace32   = '0;
  int          periods8  = 0;
  int          periods32 = 0;
  int          shifts8   = 0;

  always @(posedge tck8) begin
    trace8   <= {trace8[62:0], tms8};
    periods8 <= periods8 + 1;
    if (tap8 == CAPDR) dr8 <= idcode8;
    else if (tap8 == SHDR) begin
      dr8     <= {1'b0, dr8[7:1]};
      shifts8 <= shifts8 + 1;
    end
    tap8 <= tap_next(tap8, tms8);
  end
  always @(negedge tck8) tdo8 <= dr8[0];

  always @(posedge tck32) begin
    trace32   <= {trace32[62:0], tms32};
    periods32 <= periods32 + 1;
    if (tap32 == CAPDR) dr32 <= idcode32;
    else if (tap32 == SHDR) dr32 <= {1'b0, dr32[31:1]};
    tap32 <= tap_next(tap32, tms32);
  end
  always @(negedge tck32) tdo32 <= dr32[0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle START pulse; returns at the first negedge after acceptance.
  task automatic kick(input bit big);
    @(negedge clk);
    if (big) start32 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Counts BUSY cycles from the current negedge until DONE, bounded.
  task automatic run_read(input bit big, input bit poke, output int busy_n, output bit got_done);
    busy_n   = 0;
    got_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (big ? done32 : done8) begin
        got_done = 1'b1;
        break;
      end
      if (big ? busy32 : busy8) busy_n++;
      if (poke) start8 = (busy_n < 30) && (i % 4 == 1);
      @(negedge clk);
    end
    if (poke) start8 = 1'b0;
  endtask

  initial begin
    int   bn;
    bit   gd;
    int   p0;
    int   s0;

    repeat (3) @(negedge clk);
    check("rst_tck",   tck8,   1'b0);
    check("rst_tms",   tms8,   1'b1);
    check("rst_tdi",   tdi8,   1'b1);
    check("rst_busy",  busy8,  1'b0);
    check("rst_done",  done8,  1'b0);
    check("rst_id",    id8,    8'h00);
    check("rst_match", match8, 1'b0);
    check("rst_id32",  id32,   32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit read at CLK_DIV=1: 19 periods, 38 busy cycles
    p0 = periods8;
    kick(1'b0);
    check("r8_busy_start", busy8, 1'b1);
    run_read(1'b0, 1'b0, bn, gd);
    check("r8_done",        gd,            1'b1);
    check("r8_busy_cycles", bn,            38);
    check("r8_busy_low",    busy8,         1'b0);
    check("r8_id",          id8,           8'hA5);
    check("r8_match",       match8,        CHK);
    check("r8_periods",     periods8 - p0, 19);
    check("r8_tms_trace",   trace8[18:0],  19'b11111_0100_0000000_1_10);
    check("r8_tms_idle",    tms8,          1'b1);
    @(negedge clk);
    check("r8_done_pulse",  done8,  1'b0);
    check("r8_id_hold",     id8,    8'hA5);
    check("r8_match_hold",  match8, CHK);
    check("r8_tck_idle",    tck8,   1'b0);

    // mismatching IDCODE
    idcode8 = 8'h5A;
    kick(1'b0);
    run_read(1'b0, 1'b0, bn, gd);
    check("r5a_done",  gd,     1'b1);
    check("r5a_id",    id8,    8'h5A);
    check("r5a_match", match8, 1'b0);

    // restore 0xA5 as the previous ID, then abort mid-shift
    idcode8 = 8'hA5;
    kick(1'b0);
    run_read(1'b0, 1'b0, bn, gd);
    check("pre_id", id8, 8'hA5);
    s0 = shifts8;
    kick(1'b0);
    for (int i = 0; i < 400 && (shifts8 - s0) < 3; i++) @(negedge clk);
    check("abort_reach_bit3", shifts8 - s0, 3);
    check("abort_busy_pre",   busy8,        1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tck",   tck8,   1'b0);
    check("abort_tms",   tms8,   1'b1);
    check("abort_tdi",   tdi8,   1'b1);
    check("abort_busy",  busy8,  1'b0);
    check("abort_done",  done8,  1'b0);
    check("abort_id",    id8,    8'h00);
    check("abort_match", match8, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_no_done", done8, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_id_after", id8, 8'h00);
    kick(1'b0);
    run_read(1'b0, 1'b0, bn, gd);
    check("rec_done",        gd,  1'b1);
    check("rec_busy_cycles", bn,  38);
    check("rec_id",          id8, 8'hA5);

    // START held high: back-to-back reads
    @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    run_read(1'b0, 1'b0, bn, gd);
    check("held_done1",  gd,    1'b1);
    check("held_busy1",  bn,    38);
    @(negedge clk);
    check("held_restart", busy8, 1'b1);
    start8 = 1'b0;
    run_read(1'b0, 1'b0, bn, gd);
    check("held_done2",  gd, 1'b1);
    check("held_busy2",  bn, 38);

    // START pulses while BUSY are neither honoured nor queued
    kick(1'b0);
    run_read(1'b0, 1'b1, bn, gd);
    check("poke_done",  gd, 1'b1);
    check("poke_busy",  bn, 38);
    @(negedge clk);
    check("poke_no_queue", busy8, 1'b0);

    // 32-bit read at CLK_DIV=4: 43 periods, 344 busy cycles
    p0 = periods32;
    kick(1'b1);
    check("r32_busy_start", busy32, 1'b1);
    run_read(1'b1, 1'b0, bn, gd);
    check("r32_done",        gd,             1'b1);
    check("r32_busy_cycles", bn,             344);
    check("r32_id",          id32,           32'h1234_5679);
    check("r32_match",       match32,        CHK);
    check("r32_periods",     periods32 - p0, 43);
    check("r32_tms_trace",   trace32[42:0],  {5'b11111, 4'b0100, 31'd0, 1'b1, 2'b10});
    check("r32_tdi",         tdi32,          1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
